bus_wait_ctrl: RTL and testbench

- Wait-state sequencer between the address decoder's active-low chip selects and the 6502 RDY line.
- Each CPU bus cycle is stretched by a per-device programmable number of clocks, so slow peripherals (SID, VIAs, UART) get enough access time. RAM and Bifröst registers run at zero wait by default.
- Wait counts are configured through a small register port driven by the Bifröst register file.

---
 rtl/bus_wait_ctrl.sv | 149 ++++++++++++++
 tb/tb_bus_wait_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// Wait-state sequencer: stretches 6502 bus cycles per decoded device by driving RDY low.
// Optional stall statistics counter enabled by defining BUS_WAIT_STATS_EN.
module bus_wait_ctrl #(
  parameter int unsigned WAIT_W = 4,
  parameter int unsigned NDEV   = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            cycle_start,
  input  logic            ram_cs,
  input  logic            sid_cs,
  input  logic            via1_cs,
  input  logic            via2_cs,
  input  logic            uart_cs,
  input  logic            bifrost_cs,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_sel,
  input  logic [7:0]      cfg_wdata,
  output logic [7:0]      cfg_rdata,
  output logic            rdy,
  output logic [NDEV-1:0] dev_sel,
  output logic            busy
);

  localparam int unsigned IDX_W = $clog2(NDEV);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   cnt, cnt_nxt;
  logic                rdy_nxt, busy_nxt, err, err_nxt, err_set;
  logic [NDEV-1:0]     dev_nxt;
  logic [WAIT_W-1:0]   wreg [NDEV];
  logic [NDEV-1:0]     act;
  logic [IDX_W-1:0]    win_idx;
  logic                multi;
  logic                err_clr;
  logic                unused_wdata;

  assign unused_wdata = ^cfg_wdata[7:WAIT_W];
  assign err_clr      = cfg_we && (cfg_sel == 3'd6) && cfg_wdata[0];

  // Active-high selects; the highest index wins (bifrost > ... > ram)
  always_comb begin
    act     = ~{bifrost_cs, uart_cs, via2_cs, via1_cs, sid_cs, ram_cs};
    win_idx = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (act[i]) win_idx = IDX_W'(i);
    end
    multi = |(act & (act - NDEV'(1)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      rdy     <= 1'b1;
      busy    <= 1'b0;
      dev_sel <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdy     <= rdy_nxt;
      busy    <= busy_nxt;
      dev_sel <= dev_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdy_nxt   = rdy;
    busy_nxt  = busy;
    dev_nxt   = dev_sel;
    err_set   = 1'b0;
    case (state)
      S_IDLE: begin
        dev_nxt = '0;
        if (cycle_start && (|act)) begin
          dev_nxt = NDEV'(1) << win_idx;
          err_set = multi;
          if (wreg[win_idx] != '0) begin
            cnt_nxt   = wreg[win_idx];
            rdy_nxt   = 1'b0;
            busy_nxt  = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) begin
          rdy_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          dev_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new error in the same clock as a clear keeps err set
    err_nxt = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

  // Per-device wait registers; a running wait already holds its own copy in cnt
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wreg[0] <= WAIT_W'(0);
      wreg[1] <= WAIT_W'(3);
      wreg[2] <= WAIT_W'(1);
      wreg[3] <= WAIT_W'(1);
      wreg[4] <= WAIT_W'(2);
      wreg[5] <= WAIT_W'(0);
    end else if (cfg_we && (cfg_sel < 3'(NDEV))) begin
      wreg[IDX_W'(cfg_sel)] <= cfg_wdata[WAIT_W-1:0];
    end
  end

`ifdef BUS_WAIT_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (cfg_we && (cfg_sel == 3'd7)) begin
      stall_cnt <= '0;
    end else if (!rdy && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  always_comb begin
    cfg_rdata = '0;
    if (cfg_sel < 3'(NDEV)) begin
      cfg_rdata = 8'(wreg[IDX_W'(cfg_sel)]);
    end else if (cfg_sel == 3'd6) begin
      cfg_rdata = {6'b0, busy, err};
    end
`ifdef BUS_WAIT_STATS_EN
    else if (cfg_sel == 3'd7) begin
      cfg_rdata = (|stall_cnt[15:8]) ? stall_cnt[15:8] : stall_cnt[7:0];
    end
`endif
  end

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Self-checking bench for bus_wait_ctrl: vector table, directed corner sequences, random vs edge-count model.
module tb_bus_wait_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cycle_start;
  logic       ram_cs, sid_cs, via1_cs, via2_cs, uart_cs, bifrost_cs;
  logic       cfg_we;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       rdy;
  logic [5:0] dev_sel;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bus_wait_ctrl #(.WAIT_W(4), .NDEV(6)) dut (
    .clock(clock), .reset_n(reset_n), .cycle_start(cycle_start),
    .ram_cs(ram_cs), .sid_cs(sid_cs), .via1_cs(via1_cs), .via2_cs(via2_cs),
    .uart_cs(uart_cs), .bifrost_cs(bifrost_cs),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .rdy(rdy), .dev_sel(dev_sel), .busy(busy)
  );

  // Reference model: a bus cycle accepted at edge k with wait W stalls until edge k+W
  int       cyc_no, end_edge, zero_edge, m_dev;
  bit [3:0] m_wreg [6];
  bit       m_err;
  int       m_stall;

  function automatic bit m_rdy();
    return cyc_no >= end_edge;
  endfunction

  function automatic logic [5:0] m_dev_sel();
    logic [5:0] one;
    one = 6'b1;
    if (cyc_no < end_edge || cyc_no == zero_edge) return one << m_dev;
    return 6'b0;
  endfunction

  function automatic logic [7:0] m_rdata(input logic [2:0] sel);
    if (sel < 3'd6) return {4'b0, m_wreg[sel]};
    if (sel == 3'd6) return {6'b0, !m_rdy(), m_err};
`ifdef BUS_WAIT_STATS_EN
    if (m_stall >= 256) return 8'(m_stall / 256);
    return 8'(m_stall % 256);
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_reset();
    end_edge  = cyc_no;
    zero_edge = -1;
    m_dev     = 0;
    m_err     = 0;
    m_stall   = 0;
    m_wreg[0] = 0; m_wreg[1] = 3; m_wreg[2] = 1;
    m_wreg[3] = 1; m_wreg[4] = 2; m_wreg[5] = 0;
  endtask

  task automatic model_edge(input logic [5:0] cs, input logic cyc, input logic we,
                            input logic [2:0] sel, input logic [7:0] wd);
    int j, d, nact;
    logic [5:0] act;
    bit setp;
    j = cyc_no + 1;
    if (we && sel == 3'd7) m_stall = 0;
    else if (!m_rdy() && m_stall < 65535) m_stall++;
    act  = ~cs;
    setp = 0;
    if (cyc && act != 6'b0 && j > end_edge) begin
      d = 0; nact = 0;
      for (int i = 0; i < 6; i++) if (act[i]) begin d = i; nact++; end
      m_dev = d;
      setp  = (nact > 1);
      if (m_wreg[d] == 0) zero_edge = j;
      else end_edge = j + int'(m_wreg[d]);
    end
    if (setp) m_err = 1;
    else if (we && sel == 3'd6 && wd[0]) m_err = 0;
    if (we && sel < 3'd6) m_wreg[sel] = wd[3:0];
    cyc_no = j;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] csn(input int d);
    logic [5:0] one;
    one = 6'b1;
    return 6'h3F & ~(one << d);
  endfunction

  // One clock: drive on negedge, model on posedge, compare 1 time unit later
  task automatic cycle(input logic [5:0] cs, input logic cyc, input logic we,
                       input logic [2:0] sel, input logic [7:0] wd);
    @(negedge clock);
    {bifrost_cs, uart_cs, via2_cs, via1_cs, sid_cs, ram_cs} = cs;
    cycle_start = cyc; cfg_we = we; cfg_sel = sel; cfg_wdata = wd;
    @(posedge clock);
    model_edge(cs, cyc, we, sel, wd);
    #1;
    chk("model_rdy", 32'(rdy), 32'(m_rdy()));
    chk("model_busy", 32'(busy), 32'(!m_rdy()));
    chk("model_dev_sel", 32'(dev_sel), 32'(m_dev_sel()));
    chk("model_rdata", 32'(cfg_rdata), 32'(m_rdata(sel)));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    {bifrost_cs, uart_cs, via2_cs, via1_cs, sid_cs, ram_cs} = 6'h3F;
    cycle_start = 0; cfg_we = 0; cfg_sel = 0; cfg_wdata = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [5:0] cs; logic cyc; logic we; logic [2:0] sel; logic [7:0] wd;
    logic rdy; logic [5:0] dev; logic busy; logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    cyc_no = 0;
    reset_n = 1'b0;
    model_reset();
    do_reset();

    // Reset defaults, SID wait, RAM zero-wait, multi-select error and clear
    tbl.push_back('{6'h3F, 0, 0, 3'd0, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h3F, 0, 0, 3'd1, 8'h00, 1, 6'h00, 0, 8'h03});
    tbl.push_back('{6'h3F, 0, 0, 3'd2, 8'h00, 1, 6'h00, 0, 8'h01});
    tbl.push_back('{6'h3F, 0, 0, 3'd3, 8'h00, 1, 6'h00, 0, 8'h01});
    tbl.push_back('{6'h3F, 0, 0, 3'd4, 8'h00, 1, 6'h00, 0, 8'h02});
    tbl.push_back('{6'h3F, 0, 0, 3'd5, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h3F, 0, 0, 3'd7, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h3D, 1, 0, 3'd6, 8'h00, 0, 6'h02, 1, 8'h02});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 0, 6'h02, 1, 8'h02});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 0, 6'h02, 1, 8'h02});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h3E, 1, 0, 3'd0, 8'h00, 1, 6'h01, 0, 8'h00});
    tbl.push_back('{6'h3E, 1, 0, 3'd0, 8'h00, 1, 6'h01, 0, 8'h00});
    tbl.push_back('{6'h3F, 0, 0, 3'd0, 8'h00, 1, 6'h00, 0, 8'h00});
    tbl.push_back('{6'h2B, 1, 0, 3'd6, 8'h00, 0, 6'h10, 1, 8'h03});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 0, 6'h10, 1, 8'h03});
    tbl.push_back('{6'h3F, 0, 0, 3'd6, 8'h00, 1, 6'h00, 0, 8'h01});
    tbl.push_back('{6'h3F, 0, 1, 3'd6, 8'h01, 1, 6'h00, 0, 8'h00});

    foreach (tbl[i]) begin
      cycle(tbl[i].cs, tbl[i].cyc, tbl[i].we, tbl[i].sel, tbl[i].wd);
      chk($sformatf("tbl%0d_rdy", i), 32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_dev_sel", i), 32'(dev_sel), 32'(tbl[i].dev));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_rdata", i), 32'(cfg_rdata), 32'(tbl[i].rd));
    end

    // Reprogram UART during its wait: current stall stays 2, next one is 5
    cycle(csn(4), 1, 0, 3'd4, 8'h00);
    chk("reprog_first_w1", 32'(rdy), 32'(0));
    cycle(6'h3F, 0, 1, 3'd4, 8'h05);
    chk("reprog_first_w2", 32'(rdy), 32'(0));
    chk("reprog_rdata", 32'(cfg_rdata), 32'(8'h05));
    cycle(6'h3F, 0, 0, 3'd4, 8'h00);
    chk("reprog_first_end", 32'(rdy), 32'(1));
    cycle(csn(4), 1, 0, 3'd6, 8'h00);
    chk("reprog_second_w1", 32'(rdy), 32'(0));
    for (int i = 2; i <= 5; i++) begin
      // A cycle_start for SID mid-wait must be ignored
      cycle((i == 3) ? csn(1) : 6'h3F, (i == 3), 0, 3'd6, 8'h00);
      chk($sformatf("reprog_second_w%0d", i), 32'(rdy), 32'(0));
      chk($sformatf("reprog_second_dev%0d", i), 32'(dev_sel), 32'(6'h10));
    end
    cycle(6'h3F, 0, 0, 3'd6, 8'h00);
    chk("reprog_second_end", 32'(rdy), 32'(1));
    chk("ignored_cs_no_err", 32'(cfg_rdata), 32'(8'h00));

    // Reset asserted mid-wait releases RDY immediately
    cycle(csn(1), 1, 0, 3'd1, 8'h00);
    cycle(6'h3F, 0, 0, 3'd1, 8'h00);
    chk("midwait_rdy_low", 32'(rdy), 32'(0));
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(rdy), 32'(1));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_dev_sel", 32'(dev_sel), 32'(6'h00));
    do_reset();
    cycle(6'h3F, 0, 0, 3'd4, 8'h00);
    chk("rst_restores_uart", 32'(cfg_rdata), 32'(8'h02));

`ifdef BUS_WAIT_STATS_EN
    for (int a = 0; a < 2; a++) begin
      cycle(csn(1), 1, 0, 3'd7, 8'h00);
      repeat (3) cycle(6'h3F, 0, 0, 3'd7, 8'h00);
    end
    chk("stats_two_sid", 32'(cfg_rdata), 32'(8'h06));
    cycle(6'h3F, 0, 1, 3'd7, 8'h00);
    chk("stats_clear", 32'(cfg_rdata), 32'(8'h00));
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [5:0] cs;
      logic cyc, we;
      logic [2:0] sel;
      logic [7:0] wd;
      case ($urandom_range(0, 9))
        0:       cs = 6'h3F;
        1, 2:    cs = 6'($urandom);
        default: cs = csn(int'($urandom_range(0, 5)));
      endcase
      cyc = ($urandom_range(0, 9) < 4);
      we  = ($urandom_range(0, 9) == 0);
      sel = 3'($urandom);
      wd  = 8'($urandom);
      if (we && sel < 3'd6) wd[3:0] = 4'($urandom_range(0, 5));
      cycle(cs, cyc, we, sel, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
